// File: rtl/cordic_iter_core.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, valid/ready on both sides.
// alpha_table supplies the per-iteration angle constant, computed at elaboration time.

module alpha_table #(
  parameter int DEC  = 2,
  parameter int FRAC = 14,
  parameter int MOD  = 1
) (
  input  logic [$clog2(FRAC+1)-1:0] iter,
  output logic [DEC+FRAC-1:0]       alphai
);
  localparam int L    = DEC + FRAC;
  localparam int ITER = FRAC + 1;
  localparam int IW   = $clog2(ITER);

  // atan/atanh via power series; atan(1) is special-cased since its series barely converges.
  function automatic logic [L-1:0] alpha_val(input int unsigned i);
    real p, t, s, a, sc;
    p  = 1.0;
    sc = 1.0;
    for (int unsigned k = 0; k < i; k++) p = p * 0.5;
    for (int unsigned k = 0; k < FRAC; k++) sc = sc * 2.0;
    if (MOD == 0) begin
      a = p;
    end else if (i == 0) begin
      a = (MOD == 1) ? 0.78539816339744830962 : 0.0;
    end else begin
      s = 0.0;
      t = p;
      for (int unsigned k = 0; k < 40; k++) begin
        if (MOD == 1 && (k % 2) == 1) s = s - t / real'(2 * k + 1);
        else                          s = s + t / real'(2 * k + 1);
        t = t * p * p;
      end
      a = s;
    end
    return L'($rtoi(a * sc + 0.5));
  endfunction

  logic [L-1:0] rom [2**IW];

  for (genvar g = 0; g < 2**IW; g++) begin : g_rom
    localparam logic [L-1:0] AV = (g < ITER) ? alpha_val(g) : '0;
    assign rom[g] = AV;
  end

  assign alphai = rom[iter];
endmodule

module cordic_iter_core #(
  parameter int DEC  = 2,
  parameter int FRAC = 14,
  parameter int MOD  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DEC+FRAC-1:0] x_in,
  input  logic [DEC+FRAC-1:0] y_in,
  input  logic [DEC+FRAC-1:0] z_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEC+FRAC-1:0] x_out,
  output logic [DEC+FRAC-1:0] y_out,
  output logic [DEC+FRAC-1:0] z_out
);
  localparam int L    = DEC + FRAC;
  localparam int ITER = FRAC + 1;
  localparam int IW   = $clog2(ITER);
  localparam logic [IW-1:0] I0 = (MOD == -1) ? IW'(1) : '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic signed [L-1:0] x, y, z;
  logic signed [L-1:0] xs, ys, x_n, y_n, z_n;
  logic [L-1:0]        alphai;
  logic [IW-1:0]       cnt;
  logic                rep, fin, neg, need_rep, last_step;

  alpha_table #(.DEC(DEC), .FRAC(FRAC), .MOD(MOD)) u_alpha (
    .iter   (cnt),
    .alphai (alphai)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (fin)       state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Hyperbolic mode repeats i=4 and i=13 once each for convergence.
  assign need_rep  = (MOD == -1) && !rep && (cnt == IW'(4) || cnt == IW'(13));
  assign last_step = (cnt == IW'(FRAC)) && !need_rep;

  always_comb begin
    xs  = x >>> cnt;
    ys  = y >>> cnt;
    neg = z[L-1];
    x_n = x;
    if (MOD == 1)       x_n = neg ? x + ys : x - ys;
    else if (MOD == -1) x_n = neg ? x - ys : x + ys;
    y_n = neg ? y - xs : y + xs;
    z_n = neg ? z + alphai : z - alphai;
  end

  // fin adds one cycle after the last rotation to move the result into the output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      cnt   <= '0;
      rep   <= 1'b0;
      fin   <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x   <= x_in;
          y   <= y_in;
          z   <= z_in;
          cnt <= I0;
          rep <= 1'b0;
          fin <= 1'b0;
        end
        RUN: if (fin) begin
          x_out <= x;
          y_out <= y;
          z_out <= z;
        end else begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (need_rep) begin
            rep <= 1'b1;
          end else begin
            rep <= 1'b0;
            if (last_step) fin <= 1'b1;
            else           cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_iter_core.sv
// Runs CIR, LIN and HYP instances side by side on shared stimulus and checks them
// against a real-arithmetic CORDIC reference model.

module tb_cordic_iter_core;
  localparam int L = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [L-1:0] x_in, y_in, z_in;
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [L-1:0] xo [3], yo [3], zo [3];

  always #5 clk = ~clk;

  cordic_iter_core #(.DEC(2), .FRAC(14), .MOD(1)) u_cir (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid[0]),
    .out_ready(out_ready), .x_out(xo[0]), .y_out(yo[0]), .z_out(zo[0]));
  cordic_iter_core #(.DEC(2), .FRAC(14), .MOD(0)) u_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid[1]),
    .out_ready(out_ready), .x_out(xo[1]), .y_out(yo[1]), .z_out(zo[1]));
  cordic_iter_core #(.DEC(2), .FRAC(14), .MOD(-1)) u_hyp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid[2]),
    .out_ready(out_ready), .x_out(xo[2]), .y_out(yo[2]), .z_out(zo[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int lat [3];
  logic [L-1:0] rx [3], ry [3], rz [3];

  task automatic chk(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act - exp > tol || exp - act > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
    end
  endtask

  // mode 0 = circular, 1 = linear, 2 = hyperbolic
  function automatic int ref_alpha(input int mode, input int i);
    real p, v;
    p = $pow(2.0, -i);
    if (mode == 0)      v = $atan(p);
    else if (mode == 1) v = p;
    else                v = $atanh(p);
    return $rtoi(v * 16384.0 + 0.5);
  endfunction

  function automatic void model(input int mode, input logic [L-1:0] xi, yi, zi,
                                output logic [L-1:0] xr, yr, zr);
    logic signed [L-1:0] x, y, z;
    int seq[$];
    int d, xs, ys, nx, ny, nz;
    x = xi; y = yi; z = zi;
    if (mode == 2) begin
      for (int i = 1; i <= 14; i++) begin
        seq.push_back(i);
        if (i == 4 || i == 13) seq.push_back(i);
      end
    end else begin
      for (int i = 0; i <= 14; i++) seq.push_back(i);
    end
    foreach (seq[n]) begin
      d  = z[L-1] ? -1 : 1;
      xs = int'(x >>> seq[n]);
      ys = int'(y >>> seq[n]);
      if (mode == 0)      nx = int'(x) - d * ys;
      else if (mode == 1) nx = int'(x);
      else                nx = int'(x) + d * ys;
      ny = int'(y) + d * xs;
      nz = int'(z) - d * ref_alpha(mode, seq[n]);
      x = L'(nx); y = L'(ny); z = L'(nz);
    end
    xr = x; yr = y; zr = z;
  endfunction

  task automatic start(input int x, input int y, input int z);
    chk("in_ready_before_accept", int'(in_ready[0] && in_ready[1] && in_ready[2]), 1, 0);
    in_valid = 1'b1;
    x_in = L'(x); y_in = L'(y); z_in = L'(z);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Waits until every instance shows out_valid; optionally pokes in_valid while busy.
  task automatic wait_done(input bit poke);
    bit all;
    for (int k = 0; k < 3; k++) lat[k] = -1;
    all = 1'b0;
    for (int c = 1; c <= 40 && !all; c++) begin
      if (poke) begin
        in_valid = c[0];
        x_in = L'($urandom); y_in = L'($urandom); z_in = L'($urandom);
      end
      @(posedge clk);
      #1;
      all = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && lat[k] < 0) lat[k] = c;
        if (lat[k] < 0) all = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (!all) chk("out_valid_timeout", 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      rx[k] = xo[k]; ry[k] = yo[k]; rz[k] = zo[k];
    end
  endtask

  task automatic finish_txn;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_after_handshake", int'(out_valid[0] || out_valid[1] || out_valid[2]), 0, 0);
    chk("in_ready_after_handshake", int'(in_ready[0] && in_ready[1] && in_ready[2]), 1, 0);
  endtask

  task automatic check_model(input string tag, input logic [L-1:0] x, y, z);
    logic [L-1:0] ex, ey, ez;
    for (int k = 0; k < 3; k++) begin
      model(k, x, y, z, ex, ey, ez);
      chk({tag, "_lat"}, lat[k], (k == 2) ? 17 : 16, 0);
      chk({tag, "_x"}, int'($signed(rx[k])), int'($signed(ex)), 0);
      chk({tag, "_y"}, int'($signed(ry[k])), int'($signed(ey)), 0);
      chk({tag, "_z"}, int'($signed(rz[k])), int'($signed(ez)), 0);
    end
  endtask

  typedef struct {
    int mode;
    int x, y, z;
    int ex, ey, ez;
    int tx, ty, tz;
    int lat;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [L-1:0] ax, ay, az;
    bit ok;

    vecs[0] = '{0, 9949, 0, 12868, 11585, 11585, 0, 4, 4, 2, 16};
    vecs[1] = '{0, 9949, 0, -25736, 0, -16384, 0, 4, 4, 16, 16};
    vecs[2] = '{1, 8192, 0, 8192, 8192, 4096, 0, 0, 2, 4, 16};
    vecs[3] = '{2, 19784, 0, 8192, 18475, 8538, 0, 8, 8, 8, 17};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", int'(in_ready[k]), 1, 0);
      chk("reset_out_valid", int'(out_valid[k]), 0, 0);
      chk("reset_outputs", int'(xo[k] | yo[k] | zo[k]), 0, 0);
    end
    @(posedge clk);
    #1;

    foreach (vecs[n]) begin
      start(vecs[n].x, vecs[n].y, vecs[n].z);
      wait_done(1'b0);
      chk("vec_lat", lat[vecs[n].mode], vecs[n].lat, 0);
      chk("vec_x", int'($signed(rx[vecs[n].mode])), vecs[n].ex, vecs[n].tx);
      chk("vec_y", int'($signed(ry[vecs[n].mode])), vecs[n].ey, vecs[n].ty);
      chk("vec_z", int'($signed(rz[vecs[n].mode])), vecs[n].ez, vecs[n].tz);
      finish_txn();
    end

    for (int n = 0; n < 25; n++) begin
      ax = L'($urandom); ay = L'($urandom); az = L'($urandom);
      start(int'(ax), int'(ay), int'(az));
      wait_done(1'b0);
      check_model("rand", ax, ay, az);
      finish_txn();
    end

    // Backpressure with in_valid noise during RUN and DONE.
    ax = 16'd9949; ay = 16'd0; az = 16'd12868;
    start(int'(ax), int'(ay), int'(az));
    wait_done(1'b1);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      x_in = L'($urandom); y_in = L'($urandom); z_in = L'($urandom);
      @(posedge clk);
      #1;
      ok = 1'b1;
      for (int k = 0; k < 3; k++)
        if (!out_valid[k] || in_ready[k] || xo[k] != rx[k] || yo[k] != ry[k] || zo[k] != rz[k])
          ok = 1'b0;
      chk("backpressure_hold", int'(ok), 1, 0);
    end
    in_valid = 1'b0;
    finish_txn();
    check_model("backpressure", ax, ay, az);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_queued_txn", int'(out_valid[0] || out_valid[1] || out_valid[2]), 0, 0);
    end

    // Reset abort at RUN cycle 7, then a clean transaction.
    start(int'($urandom_range(0, 65535)), 0, 4000);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("abort_out_valid", int'(out_valid[k]), 0, 0);
      chk("abort_outputs", int'(xo[k] | yo[k] | zo[k]), 0, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    ax = L'($urandom); ay = L'($urandom); az = L'($urandom);
    start(int'(ax), int'(ay), int'(az));
    wait_done(1'b0);
    check_model("after_abort", ax, ay, az);
    finish_txn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, n_bad=%0d", n_bad);
    $fatal(1);
  end
endmodule
